dr_mem_responder: RTL and testbench

//  Clocked memory responder for the dual-rail 4-phase request channel that the

---
 rtl/dr_pkg.sv | 26 ++
 rtl/dr_sync.sv | 37 +++
 rtl/dr_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_dr_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail memory responder: token codes,
// controller state encoding and the token legality check.
package dr_pkg;

    localparam logic [1:0] TOK_NULL  = 2'b00;
    localparam logic [1:0] TOK_READ  = 2'b10;
    localparam logic [1:0] TOK_WRITE = 2'b01;
    localparam logic [1:0] TOK_ILL   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACCESS,
        ST_RD_ACK,
        ST_RD_REL,
        ST_WR_ACK,
        ST_ERR,
        ST_WAIT_NULL
    } state_t;

    // Only the single-rail-high codes carry a request; 11 is a rail fault.
    function automatic logic is_legal_token(input logic [1:0] tok);
        return (tok == TOK_READ) || (tok == TOK_WRITE);
    endfunction

endpackage

// File: rtl/dr_sync.sv
// Multi-flop synchroniser for an asynchronous bus. Besides the synchronised
// value it flags when the last two synchronised samples agree, so consumers
// can ignore values caught mid-transition on a multi-bit input.
module dr_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             stable
);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] prev;

    // Shift the input through the chain and keep one extra sample for the stability compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign stable = (q == prev);

endmodule

// File: rtl/dr_mem_responder.sv
// Clocked memory responder for the dual-rail 4-phase request channel.
//
// state      | meaning
// -----------|------------------------------------------------------------
// IDLE       | waiting for a non-null synchronised token
// DECODE     | waiting for the token to settle; captures addr/data/token
// ACCESS     | counting ACCESS_CYC edges; array access on the last one
// RD_ACK     | ack_read high, data_out valid; waits consumer ack and null
// RD_REL     | waits for the consumer ack to return to zero
// WR_ACK     | ack_write high; waits for the null token
// ERR        | illegal 11 token seen; waits for null, no ack
// WAIT_NULL  | token changed during ACCESS; waits for null, no ack
module dr_mem_responder
    import dr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int ACCESS_CYC  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        read_Nwrite,
    input  logic              ack_in_read,
    output logic [DATA_W-1:0] data_out,
    output logic              ack_read,
    output logic              ack_write,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        tok_sync;
    logic              tok_stable;
    logic              ack_in_sync;
    logic              ack_in_stable;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [1:0]        cap_tok;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic              tok_changed;
    logic              tok_null_ok;
    logic              ack_in_hi;
    logic              ack_in_lo;
    logic              acc_final;
    logic              mem_we;
    logic [DATA_W-1:0] mem [DEPTH];

    dr_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_tok (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (read_Nwrite),
        .q      (tok_sync),
        .stable (tok_stable)
    );

    dr_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (ack_in_read),
        .q      (ack_in_sync),
        .stable (ack_in_stable)
    );

    // Release conditions use settled values so a single glitchy sample cannot end a handshake.
    assign tok_null_ok = tok_stable && (tok_sync == TOK_NULL);
    assign ack_in_hi   = ack_in_stable && ack_in_sync;
    assign ack_in_lo   = ack_in_stable && !ack_in_sync;
    assign tok_changed = (tok_sync != cap_tok);
    assign in_range    = (32'(cap_addr) < DEPTH);
    assign mem_idx     = cap_addr[IDX_W-1:0];
    assign acc_final   = (state == ST_ACCESS) && !tok_changed && (cnt == '0);
    assign mem_we      = acc_final && (cap_tok == TOK_WRITE) && in_range;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (tok_sync != TOK_NULL) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (tok_sync == TOK_NULL) begin
                    state_nxt = ST_IDLE;
                end else if (tok_stable) begin
                    state_nxt = is_legal_token(tok_sync) ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: begin
                if (tok_changed) begin
                    state_nxt = ST_WAIT_NULL;
                end else if (cnt == '0) begin
                    state_nxt = (cap_tok == TOK_READ) ? ST_RD_ACK : ST_WR_ACK;
                end
            end
            ST_RD_ACK: begin
                if (ack_in_hi && tok_null_ok) state_nxt = ST_RD_REL;
            end
            ST_RD_REL: begin
                if (ack_in_lo) state_nxt = ST_IDLE;
            end
            ST_WR_ACK, ST_ERR, ST_WAIT_NULL: begin
                if (tok_null_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        ack_read  = 1'b0;
        ack_write = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_RD_ACK: ack_read  = 1'b1;
            ST_WR_ACK: ack_write = 1'b1;
            default: ;
        endcase
    end

    // Request capture, access down-counter, read data and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_tok  <= TOK_NULL;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            if (state == ST_DECODE && state_nxt == ST_ACCESS) begin
                cap_addr <= addr;
                cap_data <= data_in;
                cap_tok  <= tok_sync;
                cnt      <= CNT_W'(ACCESS_CYC - 1);
            end else if (state == ST_ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == ST_DECODE && state_nxt == ST_ERR) err <= 1'b1;
            if (state == ST_ACCESS && tok_changed)         err <= 1'b1;
            if (acc_final && !in_range)                    err <= 1'b1;
            if (acc_final && cap_tok == TOK_READ) begin
                data_out <= in_range ? mem[mem_idx] : '0;
            end
            if (state == ST_RD_ACK && state_nxt == ST_RD_REL) data_out <= '0;
        end
    end

    // Single-port array; written only on the last ACCESS edge of an in-range write.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= cap_data;
    end

endmodule

// File: tb/tb_dr_mem_responder.sv
// Self-checking bench for dr_mem_responder: a 256-word instance is checked
// against a word-array model, and a 128-word instance sharing the same inputs
// is checked for out-of-range handling.
module tb_dr_mem_responder;
    import dr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [15:0] data_in;
    logic [1:0]  read_Nwrite;
    logic        ack_in_read;
    logic [15:0] data_out,  data_out_b;
    logic        ack_read,  ack_read_b;
    logic        ack_write, ack_write_b;
    logic        busy,      busy_b;
    logic        err,       err_b;

    always #5 clk = ~clk;

    dr_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .ACCESS_CYC(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .read_Nwrite(read_Nwrite),
        .ack_in_read(ack_in_read), .data_out(data_out), .ack_read(ack_read),
        .ack_write(ack_write), .busy(busy), .err(err)
    );

    dr_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .ACCESS_CYC(2), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .read_Nwrite(read_Nwrite),
        .ack_in_read(ack_in_read), .data_out(data_out_b), .ack_read(ack_read_b),
        .ack_write(ack_write_b), .busy(busy_b), .err(err_b)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [15:0] d;
        int          order;
        logic [15:0] exp;
    } vec_t;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] model_mem [256];
    logic [7:0]  written_q [$];
    logic [1:0]  last_b_ack;
    logic [15:0] last_b_data;
    vec_t        tbl [12];
    bit          r_wr;
    logic [7:0]  r_a;
    logic [15:0] r_d;
    int          r_ord;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [15:0] d);
        model_mem[a] = d;
        written_q.push_back(a);
    endtask

    // Edges until the selected ack falls (0 = ack_read, 1 = ack_write); -1 if it never does.
    task automatic wait_ack_low(input bit which, output int e);
        e = -1;
        for (int i = 0; i < 20 && e < 0; i++) begin
            tick(1);
            if (which ? !ack_write : !ack_read) e = i;
        end
    endtask

    // One full 4-phase transaction. order: 0 null before consumer ack, 1 ack before null, 2 together.
    task automatic xact(input bit wr, input logic [7:0] a, input logic [15:0] d,
                        input int order, input logic [15:0] exp_rd, input string tag);
        int e;
        bit seen;
        addr        = a;
        data_in     = d;
        read_Nwrite = wr ? TOK_WRITE : TOK_READ;
        e = -1;
        for (int i = 0; i < 20 && e < 0; i++) begin
            tick(1);
            if (ack_read || ack_write) e = i;
        end
        check({tag, " ack_lat"}, e, 5);
        if (e < 0) begin
            read_Nwrite = TOK_NULL;
            ack_in_read = 1'b0;
            tick(10);
            return;
        end
        last_b_ack  = {ack_read_b, ack_write_b};
        last_b_data = data_out_b;
        check({tag, " ack_kind"}, {ack_read, ack_write}, wr ? 2'b01 : 2'b10);
        if (!wr) check({tag, " rd_data"}, data_out, exp_rd);
        addr    = 8'($urandom);
        data_in = 16'($urandom);
        if (wr) begin
            read_Nwrite = TOK_NULL;
            wait_ack_low(1'b1, e);
            check({tag, " wr_rel_lat"}, e, 3);
        end else begin
            if (order == 0) begin
                read_Nwrite = TOK_NULL;
                tick(6);
                check({tag, " hold_wo_ack"}, {ack_read, data_out}, {1'b1, exp_rd});
                ack_in_read = 1'b1;
            end else if (order == 1) begin
                ack_in_read = 1'b1;
                tick(6);
                check({tag, " hold_wo_null"}, {ack_read, data_out}, {1'b1, exp_rd});
                read_Nwrite = TOK_NULL;
            end else begin
                ack_in_read = 1'b1;
                read_Nwrite = TOK_NULL;
            end
            wait_ack_low(1'b0, e);
            check({tag, " rd_rel_lat"}, e, 3);
            check({tag, " rd_clear"}, data_out, 16'h0000);
            ack_in_read = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (!busy) seen = 1'b1;
        end
        check({tag, " idle"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h3C, 16'hBEEF, 0, 16'h0000};
        tbl[1]  = '{1'b0, 8'h3C, 16'h0000, 2, 16'hBEEF};
        tbl[2]  = '{1'b1, 8'h00, 16'h0001, 0, 16'h0000};
        tbl[3]  = '{1'b1, 8'hFF, 16'hA5A5, 0, 16'h0000};
        tbl[4]  = '{1'b0, 8'h00, 16'h0000, 0, 16'h0001};
        tbl[5]  = '{1'b0, 8'hFF, 16'h0000, 1, 16'hA5A5};
        tbl[6]  = '{1'b1, 8'h3C, 16'h1234, 0, 16'h0000};
        tbl[7]  = '{1'b0, 8'h3C, 16'h0000, 1, 16'h1234};
        tbl[8]  = '{1'b1, 8'h7F, 16'hFFFF, 0, 16'h0000};
        tbl[9]  = '{1'b0, 8'h7F, 16'h0000, 0, 16'hFFFF};
        tbl[10] = '{1'b1, 8'h80, 16'h8001, 0, 16'h0000};
        tbl[11] = '{1'b0, 8'hFF, 16'h0000, 2, 16'hA5A5};

        // Reset held for three edges with a read token present.
        rst_n       = 1'b0;
        read_Nwrite = TOK_READ;
        addr        = 8'h00;
        data_in     = 16'h0000;
        ack_in_read = 1'b0;
        tick(3);
        check("reset outs", {ack_read, ack_write, busy, err, data_out}, 20'h0);
        check("reset outs_b", {ack_read_b, ack_write_b, busy_b, err_b, data_out_b}, 20'h0);
        read_Nwrite = TOK_NULL;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        check("post-reset quiet", {ack_read, ack_write, busy, err}, 4'h0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            xact(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].order, tbl[i].exp, $sformatf("tbl%0d", i));
            if (tbl[i].wr) model_write(tbl[i].a, tbl[i].d);
        end
        check("tbl err", err, 1'b0);

        // Random traffic against the array model.
        for (int i = 0; i < 40; i++) begin
            r_wr  = ($urandom_range(0, 1) == 1);
            r_ord = $urandom_range(0, 2);
            r_d   = 16'($urandom);
            if (r_wr) begin
                r_a = 8'($urandom);
                xact(1'b1, r_a, r_d, r_ord, 16'h0000, $sformatf("rnd%0d", i));
                model_write(r_a, r_d);
            end else begin
                r_a = written_q[$urandom_range(0, written_q.size() - 1)];
                xact(1'b0, r_a, r_d, r_ord, model_mem[r_a], $sformatf("rnd%0d", i));
            end
            tick($urandom_range(0, 3));
        end
        check("rnd err", err, 1'b0);

        // Illegal 11 token held for four edges.
        addr        = 8'h3C;
        data_in     = 16'hDEAD;
        read_Nwrite = TOK_ILL;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("ill noack%0d", i), {ack_read, ack_write}, 2'b00);
        end
        check("ill err", {err, busy}, 2'b11);
        read_Nwrite = TOK_NULL;
        tick(8);
        check("ill recover", {err, busy}, 2'b10);
        xact(1'b0, 8'h3C, 16'h0000, 2, model_mem[8'h3C], "ill readback");
        check("ill err sticky", err, 1'b1);

        // Token flips write->read during ACCESS.
        do_reset();
        check("rst clears err", err, 1'b0);
        addr        = 8'h3C;
        data_in     = 16'h0BAD;
        read_Nwrite = TOK_WRITE;
        tick(3);
        read_Nwrite = TOK_READ;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check($sformatf("flip noack%0d", i), {ack_read, ack_write}, 2'b00);
        end
        check("flip err", {err, busy}, 2'b11);
        read_Nwrite = TOK_NULL;
        tick(8);
        check("flip recover", busy, 1'b0);
        xact(1'b0, 8'h3C, 16'h0000, 0, model_mem[8'h3C], "flip readback");

        // Address boundaries: last word of the full array, first word past the small one.
        do_reset();
        xact(1'b1, 8'hFF, 16'hC0DE, 0, 16'h0000, "bnd wrFF");
        model_write(8'hFF, 16'hC0DE);
        xact(1'b1, 8'h80, 16'h5A5A, 0, 16'h0000, "bnd wr80");
        model_write(8'h80, 16'h5A5A);
        check("bnd wr80 b ack", last_b_ack, 2'b01);
        check("bnd wr errs", {err, err_b}, 2'b01);
        do_reset();
        xact(1'b0, 8'h80, 16'h0000, 2, model_mem[8'h80], "bnd rd80");
        check("bnd rd80 b ack", last_b_ack, 2'b10);
        check("bnd rd80 b data", last_b_data, 16'h0000);
        check("bnd rd80 errs", {err, err_b}, 2'b01);
        xact(1'b0, 8'hFF, 16'h0000, 1, model_mem[8'hFF], "bnd rdFF");
        check("bnd rdFF err", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
